gpio_apb_arbiter: RTL and testbench



---
 rtl/gpio_arb_pkg.sv | 19 +
 rtl/gpio_rr_arbiter.sv | 39 +++
 rtl/gpio_apb_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO APB arbiter.
//   arb_state_e : APB master phase (IDLE / SETUP / ACCESS)
//   GPIO*_*     : register offsets of the GPIO slave (banks A and B)
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam logic [7:0] GPIOA_OE = 8'h40;
    localparam logic [7:0] GPIOA_O  = 8'h44;
    localparam logic [7:0] GPIOA_I  = 8'h48;
    localparam logic [7:0] GPIOB_OE = 8'h50;
    localparam logic [7:0] GPIOB_O  = 8'h54;
    localparam logic [7:0] GPIOB_I  = 8'h58;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from ptr+1, wrapping modulo NUM_REQ.
//   req     : request vector
//   ptr     : index of the last winner
//   gnt     : one-hot grant
//   gnt_idx : encoded grant index
//   gnt_any : at least one request present
module gpio_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        // Scan offsets 1..NUM_REQ so the previous winner is considered last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!gnt_any && req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) begin
            gnt = NUM_REQ'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Shares the GPIO block's single APB slave port between NUM_REQ requesters.
// Round-robin arbitration, APB SETUP/ACCESS sequencing, per-requester
// completion pulse with read data.
// Optional build macro GPIO_ARB_LOCK_EN adds req_lock for atomic
// read-modify-write sequences (lock owner is the only requester arbitrated).
// Ports:
//   apb_pclk, apb_prstn      : clock, async active-low reset
//   req_valid/ready/write    : per-requester handshake and direction
//   req_lock                 : (GPIO_ARB_LOCK_EN only) hold bus after this transfer
//   req_addr/req_wdata       : packed per-requester payloads, slice i = requester i
//   rsp_valid/rsp_rdata      : one-hot completion pulse and read data (0 for writes)
//   m_psel..m_pwdata/m_prdata: APB master towards the GPIO slave (no pready)
//   busy                     : transfer in SETUP or ACCESS
module gpio_apb_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      apb_pclk,
    input  logic                      apb_prstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
`ifdef GPIO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [DATA_W-1:0]         m_prdata,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q,     state_d;
    logic [IDX_W-1:0]    ptr_q,       ptr_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                can_grant;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;

`ifdef GPIO_ARB_LOCK_EN
    logic                lock_q,     lock_d;
    logic [IDX_W-1:0]    lock_own_q, lock_own_d;
    logic                sel_lock;

    // While locked, only the owner is visible to the arbiter.
    always_comb begin
        arb_req = req_valid;
        if (lock_q) begin
            arb_req = req_valid & (NUM_REQ'(1) << lock_own_q);
        end
    end
`else
    always_comb begin
        arb_req = req_valid;
    end
`endif

    gpio_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // One-hot mux of the winner's payload.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
        sel_lock  = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
                sel_write = sel_write | req_write[i];
`ifdef GPIO_ARB_LOCK_EN
                sel_lock  = sel_lock  | req_lock[i];
`endif
            end
        end
    end

    // Next-state, grant and APB phase logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        req_ready   = '0;
        can_grant   = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
        lock_d      = lock_q;
        lock_own_d  = lock_own_q;
`endif

        case (state_q)
            IDLE: begin
                can_grant = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // ptr_q still names the requester that owns this transfer.
                state_d     = IDLE;
                rsp_valid_d = NUM_REQ'(1) << ptr_q;
                rsp_rdata_d = pwrite_q ? '0 : m_prdata;
                can_grant   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (can_grant && gnt_any) begin
            req_ready = gnt;
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            ptr_d     = gnt_idx;
            pwrite_d  = sel_write;
            paddr_d   = sel_addr;
            pwdata_d  = sel_write ? sel_wdata : '0;
`ifdef GPIO_ARB_LOCK_EN
            if (sel_lock) begin
                lock_d     = 1'b1;
                lock_own_d = gnt_idx;
            end else if (lock_q && (gnt_idx == lock_own_q)) begin
                lock_d     = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef GPIO_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_own_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef GPIO_ARB_LOCK_EN
            lock_q      <= lock_d;
            lock_own_q  <= lock_own_d;
`endif
        end
    end

    assign m_psel    = psel_q;
    assign m_penable = penable_q;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = psel_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Bench for gpio_apb_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model and a response scoreboard.
module tb_gpio_apb_arbiter;
    import gpio_arb_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam logic [31:0] PIN_A   = 32'h0000_1234;
    localparam logic [31:0] PIN_B   = 32'h0000_00C3;

    logic                      apb_pclk  = 1'b0;
    logic                      apb_prstn = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write = '0;
`ifdef GPIO_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock  = '0;
`endif
    logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      m_psel, m_penable, m_pwrite, busy;
    logic [ADDR_W-1:0]         m_paddr;
    logic [DATA_W-1:0]         m_pwdata;
    logic [DATA_W-1:0]         m_prdata;

    gpio_apb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .apb_pclk  (apb_pclk),
        .apb_prstn (apb_prstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
`ifdef GPIO_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .busy      (busy)
    );

    always #5 apb_pclk = ~apb_pclk;

    int cyc = 0;
    always @(posedge apb_pclk) cyc <= cyc + 1;

    // GPIO slave: OE/OUT writable, IN returns pin constants, rest reads 0.
    logic [31:0] slv_oe_a = '0, slv_o_a = '0, slv_oe_b = '0, slv_o_b = '0;
    always_comb begin
        case (m_paddr)
            {24'h0, GPIOA_OE}: m_prdata = slv_oe_a;
            {24'h0, GPIOA_O }: m_prdata = slv_o_a;
            {24'h0, GPIOA_I }: m_prdata = PIN_A;
            {24'h0, GPIOB_OE}: m_prdata = slv_oe_b;
            {24'h0, GPIOB_O }: m_prdata = slv_o_b;
            {24'h0, GPIOB_I }: m_prdata = PIN_B;
            default:           m_prdata = '0;
        endcase
    end
    always @(posedge apb_pclk) begin
        if (m_psel && m_penable && m_pwrite) begin
            case (m_paddr)
                {24'h0, GPIOA_OE}: slv_oe_a <= m_pwdata;
                {24'h0, GPIOA_O }: slv_o_a  <= m_pwdata;
                {24'h0, GPIOB_OE}: slv_oe_b <= m_pwdata;
                {24'h0, GPIOB_O }: slv_o_b  <= m_pwdata;
                default: ;
            endcase
        end
    end

    // Counters and comparison helper
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: register contents, arbitration history, lock
    logic [31:0] mdl_oe_a = '0, mdl_o_a = '0, mdl_oe_b = '0, mdl_o_b = '0;

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        case (a)
            32'h40:  return mdl_oe_a;
            32'h44:  return mdl_o_a;
            32'h48:  return PIN_A;
            32'h50:  return mdl_oe_b;
            32'h54:  return mdl_o_b;
            32'h58:  return PIN_B;
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d);
        case (a)
            32'h40:  mdl_oe_a = d;
            32'h44:  mdl_o_a  = d;
            32'h50:  mdl_oe_b = d;
            32'h54:  mdl_o_b  = d;
            default: ;
        endcase
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   gcyc_log[$];

    logic        pend_v [NUM_REQ];
    logic        pend_w [NUM_REQ];
    logic        pend_l [NUM_REQ];
    logic [31:0] pend_a [NUM_REQ];
    logic [31:0] pend_d [NUM_REQ];

    int          rr_last  = NUM_REQ - 1;
    int          last_g   = -100;
    logic        lock_on  = 1'b0;
    int          lock_own = 0;
    logic        cur_w    = 1'b0;
    logic [31:0] cur_a    = '0;
    logic [31:0] cur_d    = '0;

    logic [31:0] addr_tab [8] = '{32'h40, 32'h44, 32'h48, 32'h50,
                                  32'h54, 32'h58, 32'h4C, 32'h60};

    task automatic model_reset();
        rr_last = NUM_REQ - 1;
        last_g  = -100;
        lock_on = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_v[i] = 1'b0;
            pend_l[i] = 1'b0;
        end
    endtask

    task automatic post(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic lk);
        pend_v[i] = 1'b1;
        pend_w[i] = w;
        pend_a[i] = a;
        pend_d[i] = d;
        pend_l[i] = lk;
    endtask

    task automatic post_rand(input int i);
        logic lk;
`ifdef GPIO_ARB_LOCK_EN
        lk = ($urandom_range(0, 4) == 0);
`else
        lk = 1'b0;
`endif
        post(i, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 7)], $urandom, lk);
    endtask

    // One clock: drive pending requests, check bus phase and grant, update model.
    task automatic step();
        int                 d;
        int                 w;
        int                 c;
        logic               exp_sel;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t               e;
        @(negedge apb_pclk);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                 = pend_v[i];
            req_write[i]                 = pend_w[i];
            req_addr[i*ADDR_W +: ADDR_W] = pend_a[i];
            req_wdata[i*DATA_W +: DATA_W] = pend_d[i];
`ifdef GPIO_ARB_LOCK_EN
            req_lock[i]                  = pend_l[i];
`endif
        end
        #1;
        d       = cyc - last_g;
        exp_sel = (d == 1) || (d == 2);
        chk("psel",    64'(m_psel),    64'(exp_sel));
        chk("busy",    64'(busy),      64'(exp_sel));
        chk("penable", 64'(m_penable), 64'(d == 2));
        if (exp_sel) begin
            chk("paddr",  64'(m_paddr),  64'(cur_a));
            chk("pwrite", 64'(m_pwrite), 64'(cur_w));
            chk("pwdata", 64'(m_pwdata), 64'(cur_d));
        end
        w = -1;
        if (d >= 2) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (rr_last + k) % NUM_REQ;
                if (w < 0 && pend_v[c] && (!lock_on || c == lock_own)) w = c;
            end
        end
        exp_rdy = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (w >= 0) begin
            cur_w = pend_w[w];
            cur_a = pend_a[w];
            cur_d = pend_w[w] ? pend_d[w] : 32'h0;
            if (pend_w[w]) begin
                mdl_wr(pend_a[w], pend_d[w]);
                e.data = 32'h0;
            end else begin
                e.data = mdl_rd(pend_a[w]);
            end
            e.idx = w;
            e.due = cyc + 3;
            exp_q.push_back(e);
            if (pend_l[w]) begin
                lock_on  = 1'b1;
                lock_own = w;
            end else if (lock_on && w == lock_own) begin
                lock_on = 1'b0;
            end
            rr_last   = w;
            last_g    = cyc;
            pend_v[w] = 1'b0;
            gnt_log.push_back(w);
            gcyc_log.push_back(cyc);
        end
    endtask

    function automatic logic any_pend();
        logic r = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) r |= pend_v[i];
        return r;
    endfunction

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || any_pend()) && n < 60) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (3) step();
    endtask

    // Response monitor: pops the scoreboard whenever the DUT completes.
    always @(negedge apb_pclk) begin
        exp_t e;
        #2;
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(NUM_REQ'(1) << e.idx));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            chk("rsp_missing", 64'(rsp_valid), 64'(NUM_REQ'(1) << exp_q[0].idx));
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_w[i] = 1'b0;
            pend_a[i] = '0;
            pend_d[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge apb_pclk);
        #1;
        chk("rst_psel",      64'(m_psel),      64'(0));
        chk("rst_penable",   64'(m_penable),   64'(0));
        chk("rst_busy",      64'(busy),        64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid),   64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata),   64'(0));
        chk("rst_paddr",     64'(m_paddr),     64'(0));
        chk("rst_pwdata",    64'(m_pwdata),    64'(0));
        chk("rst_pwrite",    64'(m_pwrite),    64'(0));
        chk("rst_req_ready", 64'(req_ready),   64'(0));
        apb_prstn = 1'b1;
        repeat (2) step();

        // Single write from req0 to OUT A
        post(0, 1'b1, {24'h0, GPIOA_O}, 32'h0000_0002, 1'b0);
        drain();
        chk("gpio_out_a", 64'(slv_o_a), 64'h2);

        // OE written by req0, read back by req1
        post(0, 1'b1, {24'h0, GPIOA_OE}, 32'h0001_E002, 1'b0);
        drain();
        post(1, 1'b0, {24'h0, GPIOA_OE}, 32'h0, 1'b0);
        drain();

        // Both requesters held valid: strict alternation, one grant per 2 cycles
        gnt_log.delete();
        gcyc_log.delete();
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NUM_REQ; i++) if (!pend_v[i]) post_rand(i);
            step();
        end
        for (int k = 1; k < gnt_log.size(); k++) begin
            chk("alt_order", 64'(gnt_log[k]), 64'((gnt_log[k-1] + 1) % NUM_REQ));
            chk("alt_gap",   64'(gcyc_log[k] - gcyc_log[k-1]), 64'(2));
        end
        drain();

        // Back-to-back from req0 alone
        gnt_log.delete();
        gcyc_log.delete();
        post(0, 1'b0, {24'h0, GPIOB_I}, 32'h0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            if (!pend_v[0] && gnt_log.size() < 2) post(0, 1'b1, {24'h0, GPIOB_O}, 32'h0000_00A5, 1'b0);
            step();
        end
        chk("b2b_count", 64'(gnt_log.size()), 64'(2));
        if (gnt_log.size() == 2) chk("b2b_gap", 64'(gcyc_log[1] - gcyc_log[0]), 64'(2));
        drain();

        // Reset during ACCESS drops the transfer
        post(0, 1'b0, {24'h0, GPIOB_I}, 32'h0, 1'b0);
        step();
        step();
        @(negedge apb_pclk);
        apb_prstn = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_psel",    64'(m_psel),    64'(0));
        chk("mid_rst_penable", 64'(m_penable), 64'(0));
        chk("mid_rst_busy",    64'(busy),      64'(0));
        if (exp_q.size() != 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        model_reset();
        @(negedge apb_pclk);
        #1;
        chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
        apb_prstn = 1'b1;
        gnt_log.delete();
        gcyc_log.delete();
        post(0, 1'b0, {24'h0, GPIOA_I}, 32'h0, 1'b0);
        post(1, 1'b0, {24'h0, GPIOB_I}, 32'h0, 1'b0);
        step();
        chk("post_rst_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'(0));
        drain();

`ifdef GPIO_ARB_LOCK_EN
        // Locked read-modify-write by req0 with req1 waiting
        gnt_log.delete();
        gcyc_log.delete();
        post(0, 1'b0, {24'h0, GPIOB_O}, 32'h0, 1'b1);
        step();
        post(1, 1'b1, {24'h0, GPIOA_O}, 32'h0000_0055, 1'b0);
        for (int n = 0; n < 10; n++) begin
            if (!pend_v[0] && gnt_log.size() == 1) post(0, 1'b1, {24'h0, GPIOB_O}, 32'h0000_0F0F, 1'b0);
            step();
        end
        chk("lock_count", 64'(gnt_log.size()), 64'(3));
        if (gnt_log.size() == 3) begin
            chk("lock_order0", 64'(gnt_log[0]), 64'(0));
            chk("lock_order1", 64'(gnt_log[1]), 64'(0));
            chk("lock_order2", 64'(gnt_log[2]), 64'(1));
        end
        drain();
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) post_rand(i);
            end
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
